// File: rtl/modport_dut_if.sv
// AHB-lite style bus bundle shared by the memory slave and whatever drives it.
//
// Signals (widths follow the parameters):
//   HADDR     byte address, address phase
//   HWDATA    write data, data phase
//   HSIZE     transfer size (0 byte, 1 halfword, 2 word)
//   HBURST    burst type (SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4,
//             INCR8=5, WRAP16=6, INCR16=7)
//   HTRANS    transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3)
//   HWRITE    1 = write, 0 = read
//   HMASTLOCK, HPROT  carried for completeness, not interpreted by the slave
//   HREADY    bus ready; a phase completes only on an edge with HREADY=1
//   HRDATA    registered read data from the slave
//   HRESP     slave response (OKAY=0, ERROR=1)
//
// Modports: master drives the request side, slave drives HRDATA/HRESP.
interface modport_dut_if #(
  parameter int DATAWIDTH        = 32,
  parameter int ADDRWIDTH        = 32,
  parameter int DATATRANFER_SIZE = 3
);
  logic [ADDRWIDTH-1:0]        HADDR;
  logic [DATAWIDTH-1:0]        HWDATA;
  logic [DATATRANFER_SIZE-1:0] HSIZE;
  logic [2:0]                  HBURST;
  logic [1:0]                  HTRANS;
  logic                        HWRITE;
  logic                        HMASTLOCK;
  logic [3:0]                  HPROT;
  logic                        HREADY;
  logic [DATAWIDTH-1:0]        HRDATA;
  logic                        HRESP;

  modport master (
    output HADDR, HWDATA, HSIZE, HBURST, HTRANS, HWRITE, HMASTLOCK, HPROT,
    output HREADY,
    input  HRDATA, HRESP
  );

  modport slave (
    input  HADDR, HWDATA, HSIZE, HBURST, HTRANS, HWRITE, HMASTLOCK, HPROT,
    input  HREADY,
    output HRDATA, HRESP
  );
endinterface

// File: rtl/modport_dut.sv
// Zero-wait-state AHB-lite memory slave (MEMDEPTH words of DATAWIDTH bits).
//
// Ports:
//   HCLK     sole clock, rising edge
//   HRESETn  asynchronous active-low reset
//   bus      modport_dut_if.slave: request signals in, HRDATA/HRESP out
//
// Handshake: there is no HREADYOUT. A phase completes on a rising edge only
// when HREADY=1. An address phase is taken when HREADY=1 and HTRANS is NONSEQ
// or SEQ; the following cycle(s) up to the next HREADY=1 edge are its data
// phase. While HREADY=0 the registered data-phase state (address, write flag,
// error flag, HRDATA) is held unchanged.
//
// Reads load HRDATA at the edge that accepts the address phase, so read data
// is present for the whole data phase. A write is committed at the edge that
// ends its data phase; a read accepted on that same edge to the same word sees
// the merged new word.
module modport_dut #(
  parameter int DATAWIDTH        = 32,
  parameter int ADDRWIDTH        = 32,
  parameter int DATATRANFER_SIZE = 3,
  parameter int MEMDEPTH         = 1024
) (
  input  logic            HCLK,
  input  logic            HRESETn,
  modport_dut_if.slave    bus
);
  localparam int LANES = DATAWIDTH / 8;
  localparam int IDXW  = $clog2(MEMDEPTH);

  logic [DATAWIDTH-1:0] mem [MEMDEPTH];

  // Data-phase state
  logic                 valid_q, valid_d;
  logic                 write_q, write_d;
  logic                 err_q,   err_d;
  logic [1:0]           size_q,  size_d;
  logic [IDXW+1:0]      addr_q,  addr_d;
  logic [DATAWIDTH-1:0] hrdata_q, hrdata_d;

  logic                 accept;
  logic                 req_err;
  logic                 wr_en;
  logic [LANES-1:0]     be;
  logic [IDXW-1:0]      widx;
  logic [IDXW-1:0]      ridx;
  logic [DATAWIDTH-1:0] wr_word;
  logic [DATAWIDTH-1:0] rd_word;

  always_comb begin
    accept   = 1'b0;
    req_err  = 1'b0;
    wr_en    = 1'b0;
    be       = '0;
    widx     = addr_q[IDXW+1:2];
    ridx     = bus.HADDR[IDXW+1:2];
    wr_word  = '0;
    rd_word  = '0;
    valid_d  = valid_q;
    write_d  = write_q;
    err_d    = err_q;
    size_d   = size_q;
    addr_d   = addr_q;
    hrdata_d = hrdata_q;

    // Byte enables of the pending write, little-endian lanes.
    case (size_q)
      2'd0:    be = LANES'(1) << addr_q[1:0];
      2'd1:    be = LANES'(2'b11) << {addr_q[1], 1'b0};
      default: be = '1;
    endcase

    // Merge the write data into the stored word; unselected lanes keep
    // their old contents.
    wr_word = mem[widx];
    for (int i = 0; i < LANES; i++) begin
      if (be[i]) wr_word[8*i +: 8] = bus.HWDATA[8*i +: 8];
    end

    wr_en  = valid_q & write_q & ~err_q & bus.HREADY;
    accept = bus.HREADY & bus.HTRANS[1];

    req_err = ((bus.HADDR >> 2) >= ADDRWIDTH'(MEMDEPTH))
            | (bus.HSIZE > DATATRANFER_SIZE'(2))
            | ((bus.HSIZE == DATATRANFER_SIZE'(1)) & bus.HADDR[0])
            | ((bus.HSIZE == DATATRANFER_SIZE'(2)) & (bus.HADDR[1:0] != 2'b00));

    // Forward a write completing on this edge into a read of the same word.
    rd_word = (wr_en && (ridx == widx)) ? wr_word : mem[ridx];

    if (bus.HREADY) begin
      valid_d = accept;
      if (accept) begin
        write_d = bus.HWRITE;
        err_d   = req_err;
        size_d  = bus.HSIZE[1:0];
        addr_d  = bus.HADDR[IDXW+1:0];
        if (req_err)            hrdata_d = '0;
        else if (!bus.HWRITE)   hrdata_d = rd_word;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      valid_q  <= 1'b0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= 2'd0;
      addr_q   <= '0;
      hrdata_q <= '0;
    end else begin
      valid_q  <= valid_d;
      write_q  <= write_d;
      err_q    <= err_d;
      size_q   <= size_d;
      addr_q   <= addr_d;
      hrdata_q <= hrdata_d;
    end
  end

  // Memory is not reset; a write needs valid_q, which reset clears at once,
  // so an aborted transfer never reaches the array.
  always_ff @(posedge HCLK) begin
    if (wr_en) mem[widx] <= wr_word;
  end

  assign bus.HRDATA = hrdata_q;
  assign bus.HRESP  = valid_q & err_q;

  // Accepted but not interpreted.
  logic unused_sigs;
  assign unused_sigs = ^{bus.HBURST, bus.HMASTLOCK, bus.HPROT, bus.HTRANS[0]};
endmodule

// File: tb/tb_modport_dut.sv
module tb_modport_dut;
  localparam logic [1:0] T_IDLE = 2'd0;
  localparam logic [1:0] T_NSEQ = 2'd2;
  localparam logic [1:0] T_SEQ  = 2'd3;
  localparam logic [2:0] SZ_B   = 3'd0;
  localparam logic [2:0] SZ_H   = 3'd1;
  localparam logic [2:0] SZ_W   = 3'd2;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    #7;
    forever #5 clk = ~clk;
  end

  modport_dut_if #(.DATAWIDTH(32), .ADDRWIDTH(32), .DATATRANFER_SIZE(3)) bus ();

  modport_dut #(
    .DATAWIDTH(32), .ADDRWIDTH(32), .DATATRANFER_SIZE(3), .MEMDEPTH(1024)
  ) dut (
    .HCLK    (clk),
    .HRESETn (rst_n),
    .bus     (bus)
  );

  // ---------------- scoreboard ----------------
  // entry = {check_data, expected_resp, expected_data}
  logic [33:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Data phase tracking from the bus protocol itself.
  logic tb_dphase;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)          tb_dphase <= 1'b0;
    else if (bus.HREADY) tb_dphase <= bus.HTRANS[1];
  end

  // Monitor: compares on the falling edge of each completing data phase.
  always @(negedge clk) begin
    logic [33:0] e;
    if (rst_n) begin
      if (tb_dphase) begin
        if (bus.HREADY) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL underflow: data phase with no expected entry at %0t", $time);
          end else begin
            e = exp_q.pop_front();
            chk("hresp", {31'd0, bus.HRESP}, {31'd0, e[32]});
            if (e[33]) chk("hrdata", bus.HRDATA, e[31:0]);
          end
        end
      end else begin
        chk("idle_resp", {31'd0, bus.HRESP}, 32'd0);
      end
    end
  end

  // ---------------- driver ----------------
  // One bus cycle: new address phase plus HWDATA for the previous beat.
  task automatic issue(input logic [1:0] tr, input logic wr, input logic [31:0] a,
                       input logic [2:0] sz, input logic [31:0] wd, input logic rdy,
                       input logic chk_d, input logic err, input logic [31:0] d);
    bus.HTRANS = tr;
    bus.HWRITE = wr;
    bus.HADDR  = a;
    bus.HSIZE  = sz;
    bus.HWDATA = wd;
    bus.HREADY = rdy;
    if (tr[1] && rdy) exp_q.push_back({chk_d, err, d});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [31:0] wd, input logic rdy);
    issue(T_IDLE, 1'b0, 32'h0, SZ_W, wd, rdy, 1'b0, 1'b0, 32'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.HADDR = '0; bus.HWDATA = '0; bus.HSIZE = SZ_W; bus.HBURST = 3'd0;
    bus.HTRANS = T_IDLE; bus.HWRITE = 1'b0; bus.HMASTLOCK = 1'b0;
    bus.HPROT = 4'h3; bus.HREADY = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #5;
    chk("reset_hrdata", bus.HRDATA, 32'h0);
    chk("reset_hresp", {31'd0, bus.HRESP}, 32'd0);
    #19 rst_n = 1'b1;
    @(posedge clk); #1;

    // Word write then read (first read forwarded, second from memory)
    issue(T_NSEQ, 1, 32'h10, SZ_W, 32'h0,        1, 0, 0, 32'h0);
    issue(T_NSEQ, 0, 32'h10, SZ_W, 32'hDEADBEEF, 1, 1, 0, 32'hDEADBEEF);
    idle(32'h0, 1);
    issue(T_NSEQ, 0, 32'h10, SZ_W, 32'h0,        1, 1, 0, 32'hDEADBEEF);
    idle(32'h0, 1);

    // Byte and halfword lanes
    issue(T_NSEQ, 1, 32'h20, SZ_W, 32'h0,        1, 0, 0, 32'h0);
    issue(T_NSEQ, 1, 32'h21, SZ_B, 32'h00000000, 1, 0, 0, 32'h0);
    issue(T_NSEQ, 1, 32'h22, SZ_H, 32'hFFFFAAFF, 1, 0, 0, 32'h0);
    issue(T_NSEQ, 0, 32'h20, SZ_W, 32'h1234FFFF, 1, 1, 0, 32'h1234AA00);
    idle(32'h0, 1);
    issue(T_NSEQ, 0, 32'h20, SZ_W, 32'h0,        1, 1, 0, 32'h1234AA00);
    idle(32'h0, 1);

    // INCR4 write, then back-to-back INCR4 read
    bus.HBURST = 3'd3;
    for (int i = 0; i < 4; i++)
      issue((i == 0) ? T_NSEQ : T_SEQ, 1, 32'h40 + 32'(4*i), SZ_W, 32'(i), 1, 0, 0, 32'h0);
    for (int i = 0; i < 4; i++)
      issue((i == 0) ? T_NSEQ : T_SEQ, 0, 32'h40 + 32'(4*i), SZ_W,
            (i == 0) ? 32'd4 : 32'd0, 1, 1, 0, 32'(i + 1));
    bus.HBURST = 3'd0;
    idle(32'h0, 1);

    // Error transfers; word 0 must keep its value
    issue(T_NSEQ, 1, 32'h0,    SZ_W,  32'h0,        1, 0, 0, 32'h0);
    issue(T_NSEQ, 1, 32'h1000, SZ_W,  32'h11111111, 1, 0, 1, 32'h0);
    issue(T_NSEQ, 1, 32'h02,   SZ_W,  32'hBAD0BAD0, 1, 0, 1, 32'h0);
    issue(T_NSEQ, 1, 32'h00,   3'd3,  32'hBAD1BAD1, 1, 0, 1, 32'h0);
    issue(T_NSEQ, 0, 32'h1000, SZ_W,  32'hBAD2BAD2, 1, 1, 1, 32'h0);
    issue(T_NSEQ, 0, 32'h01,   SZ_H,  32'h0,        1, 1, 1, 32'h0);
    issue(T_NSEQ, 0, 32'h00,   SZ_W,  32'h0,        1, 1, 0, 32'h11111111);
    // Last valid word
    issue(T_NSEQ, 1, 32'hFFC,  SZ_W,  32'h0,        1, 0, 0, 32'h0);
    issue(T_NSEQ, 0, 32'hFFC,  SZ_W,  32'hCAFEF00D, 1, 1, 0, 32'hCAFEF00D);
    idle(32'h0, 1);

    // Wait states during a write data phase
    issue(T_NSEQ, 1, 32'h50, SZ_W, 32'h0, 1, 0, 0, 32'h0);
    idle(32'h55, 0);
    idle(32'h55, 0);
    issue(T_NSEQ, 0, 32'h50, SZ_W, 32'h55, 1, 1, 0, 32'h00000055);
    idle(32'h0, 1);

    // Reset during a stalled write: no write may reach memory
    issue(T_NSEQ, 1, 32'h54, SZ_W, 32'h0, 1, 0, 0, 32'h0);
    idle(32'h0000A5A5, 1);
    issue(T_NSEQ, 1, 32'h54, SZ_W, 32'h0, 1, 0, 0, 32'h0);
    idle(32'h77, 0);
    idle(32'h77, 0);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("abort_hrdata", bus.HRDATA, 32'h0);
    chk("abort_hresp", {31'd0, bus.HRESP}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    issue(T_NSEQ, 0, 32'h54, SZ_W, 32'h77, 1, 1, 0, 32'h0000A5A5);
    idle(32'h0, 1);
    idle(32'h0, 1);
    idle(32'h0, 1);

    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    total++;
    bad++;
    $display("FAIL timeout: run did not finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
